// File: rtl/board_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : board_io_ctrl
// Description : Board-level I/O front end. Synchronises and debounces raw
//               push-buttons and slide-switches, produces press/release and
//               switch-change pulses, and drives LEDs in direct, blink,
//               heartbeat or walking-one mode from a free-running prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
module board_io_ctrl #(
    parameter int NUM_BTN         = 5,
    parameter int NUM_SW          = 8,
    parameter int NUM_LED         = 8,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int BLINK_LOG2      = 24,
    parameter int SYNC_STAGES     = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic [NUM_SW-1:0]  sw_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_SW-1:0]  sw_level,
    output logic               sw_change,
    input  logic [NUM_LED-1:0] led_value,
    input  logic [1:0]         led_mode,
    output logic [NUM_LED-1:0] led_out
);

    // Buttons and switches share one debounce datapath: buttons occupy the
    // low bits, switches the high bits.
    localparam int                  c_NUM_IN    = NUM_BTN + NUM_SW;
    localparam int                  c_CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int                  c_WALK_W    = $clog2(NUM_LED);
    // The counter is compared one short of the threshold so that the level
    // updates on the same edge at which the count would reach it.
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_WALK_W-1:0] c_WALK_LAST = c_WALK_W'(NUM_LED - 1);
    localparam logic [NUM_LED-1:0]  c_LED_ONE   = NUM_LED'(1);

    logic [c_NUM_IN-1:0]                  w_raw;
    logic [SYNC_STAGES-1:0][c_NUM_IN-1:0] r_sync;
    logic [c_NUM_IN-1:0]                  w_sync;
    logic [c_NUM_IN-1:0]                  r_level;
    logic [c_NUM_IN-1:0]                  w_level_nxt;
    logic [NUM_BTN-1:0]                   r_btn_press;
    logic [NUM_BTN-1:0]                   r_btn_release;
    logic                                 r_sw_change;
    logic [BLINK_LOG2-1:0]                r_presc;
    logic                                 w_wrap;
    logic                                 r_blink;
    logic [c_WALK_W-1:0]                  r_walk;
    logic [NUM_LED-1:0]                   w_led_nxt;
    logic [NUM_LED-1:0]                   r_led;

    assign w_raw  = {sw_in, btn_in};
    assign w_sync = r_sync[SYNC_STAGES-1];

    // Synchroniser chain: every raw input crosses SYNC_STAGES flops first.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= w_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    // Per-bit stability counter; a bit flips only after a full run of
    // consecutive differing synchronised samples.
    for (genvar i = 0; i < c_NUM_IN; i++) begin : g_debounce
        logic [c_CNT_W-1:0] r_cnt;
        logic               w_diff;
        logic               w_hit;

        assign w_diff         = w_sync[i] != r_level[i];
        assign w_hit          = w_diff && (r_cnt == c_CNT_LAST);
        assign w_level_nxt[i] = w_hit ? w_sync[i] : r_level[i];

        // Count while the input disagrees, clear on agreement or acceptance.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_cnt <= '0;
            end else if (!w_diff || w_hit) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Debounced levels and the edge pulses, all aligned to the level change.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_level       <= '0;
            r_btn_press   <= '0;
            r_btn_release <= '0;
            r_sw_change   <= 1'b0;
        end else begin
            r_level       <= w_level_nxt;
            r_btn_press   <= w_level_nxt[NUM_BTN-1:0] & ~r_level[NUM_BTN-1:0];
            r_btn_release <= ~w_level_nxt[NUM_BTN-1:0] & r_level[NUM_BTN-1:0];
            r_sw_change   <= |(w_level_nxt[c_NUM_IN-1:NUM_BTN] ^ r_level[c_NUM_IN-1:NUM_BTN]);
        end
    end

    assign w_wrap = &r_presc;

    // Free-running prescaler, blink toggle and walk index; independent of mode.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_presc <= '0;
            r_blink <= 1'b0;
            r_walk  <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
            if (w_wrap) begin
                r_blink <= ~r_blink;
                // Advance only on the rising toggle of blink.
                if (!r_blink) begin
                    r_walk <= (r_walk == c_WALK_LAST) ? '0 : r_walk + 1'b1;
                end
            end
        end
    end

    // LED pattern selection from the current mode.
    always_comb begin
        w_led_nxt = '0;
        case (led_mode)
            2'd0:    w_led_nxt = led_value;
            2'd1:    w_led_nxt = led_value & {NUM_LED{r_blink}};
            2'd2:    w_led_nxt = {led_value[NUM_LED-1:1], r_blink};
            default: w_led_nxt = c_LED_ONE << r_walk;
        endcase
    end

    // Registered LED drive.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_nxt;
        end
    end

    assign btn_level   = r_level[NUM_BTN-1:0];
    assign sw_level    = r_level[c_NUM_IN-1:NUM_BTN];
    assign btn_press   = r_btn_press;
    assign btn_release = r_btn_release;
    assign sw_change   = r_sw_change;
    assign led_out     = r_led;

endmodule
`default_nettype wire

// File: tb/tb_board_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_io_ctrl
// Description : Self-checking bench for board_io_ctrl. Each scenario pushes
//               the expected output snapshot for every cycle into a queue
//               and pops/compares it as the DUT produces each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_io_ctrl;

    localparam int NB = 5;
    localparam int NS = 8;
    localparam int NL = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [NB-1:0] btn_in = '0;
    logic [NS-1:0] sw_in = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NS-1:0] sw_level;
    logic          sw_change;
    logic [NL-1:0] led_value = '0;
    logic [1:0]    led_mode = 2'd0;
    logic [NL-1:0] led_out;

    // {btn_level, btn_press, btn_release, sw_level, sw_change, led_out}
    logic [31:0]   obs;
    logic [31:0]   exp_v;
    logic [31:0]   sb[$];
    int            vectors = 0;
    int            miscompares = 0;

    board_io_ctrl #(
        .NUM_BTN        (NB),
        .NUM_SW         (NS),
        .NUM_LED        (NL),
        .DEBOUNCE_CYCLES(4),
        .BLINK_LOG2     (3),
        .SYNC_STAGES    (2)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .btn_in     (btn_in),
        .sw_in      (sw_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .sw_level   (sw_level),
        .sw_change  (sw_change),
        .led_value  (led_value),
        .led_mode   (led_mode),
        .led_out    (led_out)
    );

    always #5 clk = ~clk;

    assign obs = {btn_level, btn_press, btn_release, sw_level, sw_change, led_out};

    function automatic logic [31:0] pack(input logic [4:0] bl, input logic [4:0] bp,
                                         input logic [4:0] br, input logic [7:0] sl,
                                         input logic sc, input logic [7:0] lo);
        return {bl, bp, br, sl, sc, lo};
    endfunction

    // Outputs stay zero while reset is held, whatever the inputs do.
    task automatic test_reset();
        rstn      = 1'b0;
        btn_in    = '1;
        sw_in     = '1;
        led_value = 8'hFF;
        led_mode  = 2'd0;
        for (int i = 0; i < 4; i++) sb.push_back('0);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset cyc %0d: got %h expected %h", i, obs, exp_v);
            end
        end
        btn_in    = '0;
        sw_in     = '0;
        led_value = '0;
        rstn      = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back('0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset_exit cyc %0d: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    // Held press and release of button 0: level and pulse 6 cycles after edge.
    task automatic test_btn_press();
        btn_in = 5'b00001;
        for (int i = 1; i <= 8; i++)
            sb.push_back(pack((i >= 6) ? 5'h01 : 5'h00, (i == 6) ? 5'h01 : 5'h00, 5'h00, 8'h00, 1'b0, 8'h00));
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL btn_press cyc %0d: got %h expected %h", i, obs, exp_v);
            end
        end
        btn_in = 5'b00000;
        for (int i = 1; i <= 8; i++)
            sb.push_back(pack((i >= 6) ? 5'h00 : 5'h01, 5'h00, (i == 6) ? 5'h01 : 5'h00, 8'h00, 1'b0, 8'h00));
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL btn_release cyc %0d: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    // A 3-cycle pulse on button 1 is rejected.
    task automatic test_glitch();
        btn_in = 5'b00010;
        for (int i = 0; i < 10; i++) sb.push_back('0);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL glitch cyc %0d: got %h expected %h", i, obs, exp_v);
            end
            if (i == 3) btn_in = 5'b00000;
        end
    endtask

    // Several buttons together, then staggered releases on consecutive cycles.
    task automatic test_back_to_back();
        btn_in = 5'b10011;
        for (int i = 1; i <= 8; i++)
            sb.push_back(pack((i >= 6) ? 5'h13 : 5'h00, (i == 6) ? 5'h13 : 5'h00, 5'h00, 8'h00, 1'b0, 8'h00));
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL multi_press cyc %0d: got %h expected %h", i, obs, exp_v);
            end
        end
        btn_in = 5'b10010;
        for (int i = 1; i <= 9; i++)
            sb.push_back(pack((i <= 5) ? 5'h13 : (i == 6) ? 5'h12 : 5'h02, 5'h00,
                              (i == 6) ? 5'h01 : (i == 7) ? 5'h10 : 5'h00, 8'h00, 1'b0, 8'h00));
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL stagger_release cyc %0d: got %h expected %h", i, obs, exp_v);
            end
            if (i == 1) btn_in = 5'b00010;
        end
        btn_in = 5'b00000;
        for (int i = 1; i <= 8; i++)
            sb.push_back(pack((i >= 6) ? 5'h00 : 5'h02, 5'h00, (i == 6) ? 5'h02 : 5'h00, 8'h00, 1'b0, 8'h00));
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL last_release cyc %0d: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    // Simultaneous switch change gives one pulse; changes on adjacent cycles give two.
    task automatic test_sw_change();
        sw_in = 8'h81;
        for (int i = 1; i <= 8; i++)
            sb.push_back(pack(5'h00, 5'h00, 5'h00, (i >= 6) ? 8'h81 : 8'h00, i == 6, 8'h00));
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL sw_simul cyc %0d: got %h expected %h", i, obs, exp_v);
            end
        end
        sw_in = 8'h01;
        for (int i = 1; i <= 9; i++)
            sb.push_back(pack(5'h00, 5'h00, 5'h00, (i <= 5) ? 8'h81 : (i == 6) ? 8'h01 : 8'h00,
                              (i == 6) || (i == 7), 8'h00));
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL sw_stagger cyc %0d: got %h expected %h", i, obs, exp_v);
            end
            if (i == 1) sw_in = 8'h00;
        end
    endtask

    // Reset mid-count discards progress; input still high afterwards is a new edge.
    task automatic test_reset_mid();
        btn_in    = 5'b00100;
        led_value = 8'h5A;
        for (int i = 0; i < 4; i++) sb.push_back(pack(5'h00, 5'h00, 5'h00, 8'h00, 1'b0, 8'h5A));
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL pre_reset cyc %0d: got %h expected %h", i, obs, exp_v);
            end
        end
        rstn = 1'b0;
        #2;
        sb.push_back('0);
        exp_v = sb.pop_front();
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected %h", obs, exp_v);
        end
        for (int i = 0; i < 3; i++) sb.push_back('0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL in_reset cyc %0d: got %h expected %h", i, obs, exp_v);
            end
        end
        rstn = 1'b1;
        for (int i = 1; i <= 8; i++)
            sb.push_back(pack((i >= 6) ? 5'h04 : 5'h00, (i == 6) ? 5'h04 : 5'h00, 5'h00, 8'h00, 1'b0, 8'h5A));
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL post_reset_press cyc %0d: got %h expected %h", i, obs, exp_v);
            end
        end
        btn_in    = 5'b00000;
        led_value = 8'h00;
        for (int i = 1; i <= 8; i++)
            sb.push_back(pack((i >= 6) ? 5'h00 : 5'h04, 5'h00, (i == 6) ? 5'h04 : 5'h00, 8'h00, 1'b0, 8'h00));
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL post_reset_release cyc %0d: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    // Walking one from reset: one step per 16 cycles, wrapping back to bit 0.
    task automatic test_led_walk();
        rstn     = 1'b0;
        led_mode = 2'd3;
        @(posedge clk); #1;
        rstn = 1'b1;
        // After the n-th edge led_out shows walk index floor((n+7)/16) mod 8.
        for (int n = 1; n <= 140; n++) begin
            logic [7:0] one;
            one = 8'h01;
            sb.push_back(pack(5'h00, 5'h00, 5'h00, 8'h00, 1'b0, one << (((n + 7) / 16) % 8)));
        end
        for (int n = 1; n <= 140; n++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL walk cyc %0d: got %h expected %h", n, obs, exp_v);
            end
        end
    endtask

    // Blink then heartbeat without resetting the timebase, then direct mode.
    task automatic test_led_blink();
        rstn      = 1'b0;
        led_mode  = 2'd1;
        led_value = 8'hF0;
        @(posedge clk); #1;
        rstn = 1'b1;
        // Blink after the n-th edge is floor(n/8) mod 2; led_out lags by one.
        for (int n = 1; n <= 66; n++) begin
            logic b;
            logic [7:0] lo;
            b = (((n - 1) / 8) % 2) == 1;
            if (n <= 32)      lo = b ? 8'hF0 : 8'h00;
            else if (n <= 64) lo = b ? 8'hF1 : 8'hF0;
            else              lo = 8'hA5;
            sb.push_back(pack(5'h00, 5'h00, 5'h00, 8'h00, 1'b0, lo));
        end
        for (int n = 1; n <= 66; n++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL led_mode cyc %0d: got %h expected %h", n, obs, exp_v);
            end
            if (n == 32) led_mode = 2'd2;
            if (n == 64) begin
                led_mode  = 2'd0;
                led_value = 8'hA5;
            end
        end
    endtask

    initial begin
        test_reset();
        test_btn_press();
        test_glitch();
        test_back_to_back();
        test_sw_change();
        test_reset_mid();
        test_led_walk();
        test_led_blink();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
